// File: rtl/logic_result_checker.sv
// logic_result_checker: samples the 3-input AND/OR stage (out_1/out_2) against a
// reference model, tallies pass/fail counts per run and queues mismatching
// vectors in a small FIFO drained over a ready/valid port.
// Optional build macro CHECKER_DISPLAY_EN adds simulation-only mismatch and
// end-of-run $display output; functional behaviour is unchanged.
module logic_result_checker #(
    parameter int unsigned NUM_VECTORS = 8,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             smp_valid,
    input  logic [2:0]       in_vec,
    input  logic             out_1,
    input  logic             out_2,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             ovf,
    output logic             err_valid,
    input  logic             err_ready,
    output logic [4:0]       err_data
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'(NUM_VECTORS - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, done_q;

    logic [4:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W:0]   remain;
    logic [4:0]       head_q, head_d;

    logic       exp_1, exp_2;
    logic       start_run, sample, match, push, push_ok, pop, full;
    logic [4:0] push_data;

    // Reference model of the AND/OR stage and per-cycle event decode
    always_comb begin
        exp_1     = in_vec[0] & in_vec[1] & in_vec[2];
        exp_2     = (in_vec[0] & in_vec[1]) | in_vec[2];
        match     = (out_1 == exp_1) && (out_2 == exp_2);
        sample    = smp_valid && (state_q == StRun);
        start_run = start && (state_q != StRun);
        full      = (count_q == FULL_CNT);
        pop       = (count_q != '0) && err_ready;
        push      = sample && !match;
        // A full FIFO still accepts a push if the head leaves in the same cycle
        push_ok   = push && (!full || pop);
        push_data = {in_vec, out_1, out_2};
    end

    // Next-state for FSM, counters, overflow flag and FIFO bookkeeping
    always_comb begin
        state_d   = state_q;
        smp_cnt_d = smp_cnt_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        ovf_d     = ovf_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        head_d    = head_q;
        remain    = count_q - (PTR_W + 1)'(pop);

        unique case (state_q)
            StIdle, StDone: if (start_run) state_d = StRun;
            StRun: if (sample && (smp_cnt_q == LAST_SMP)) state_d = StDone;
            default: state_d = StIdle;
        endcase

        if (start_run) begin
            smp_cnt_d = '0;
            pass_d    = '0;
            fail_d    = '0;
            ovf_d     = 1'b0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
        end else begin
            if (sample) begin
                smp_cnt_d = smp_cnt_q + 1'b1;
                if (match) begin
                    if (pass_q != CNT_MAX) pass_d = pass_q + 1'b1;
                end else begin
                    if (fail_q != CNT_MAX) fail_d = fail_q + 1'b1;
                end
            end
            if (push && !push_ok) ovf_d = 1'b1;
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
            count_d  = remain + (PTR_W + 1)'(push_ok);
            // Head register tracks the oldest entry; it holds when the FIFO drains
            if (count_d != '0) begin
                head_d = (remain == '0) ? push_data : mem_q[rd_ptr_d];
            end
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            smp_cnt_q <= '0;
            pass_q    <= '0;
            fail_q    <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            head_q    <= '0;
        end else begin
            state_q   <= state_d;
            smp_cnt_q <= smp_cnt_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            ovf_q     <= ovf_d;
            busy_q    <= (state_d == StRun);
            done_q    <= (state_d == StDone);
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            head_q    <= head_d;
        end
    end

    // FIFO storage; contents are meaningless outside the valid window
    always_ff @(posedge clk) begin
        if (!rst && !start_run && push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass_cnt  = pass_q;
    assign fail_cnt  = fail_q;
    assign ovf       = ovf_q;
    assign err_valid = (count_q != '0);
    assign err_data  = head_q;

`ifdef CHECKER_DISPLAY_EN
    // Simulation-only trace of mismatches and the end-of-run tally
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            $display("%0t checker mismatch: in_vec=%b got out_1=%b out_2=%b exp out_1=%b out_2=%b",
                     $time, in_vec, out_1, out_2, exp_1, exp_2);
        end
        if (!rst && (state_q == StRun) && (state_d == StDone)) begin
            $display("PASS %0d FAIL %0d", pass_d, fail_d);
        end
    end
`else
    // Display hooks compiled out
`endif

endmodule

// File: tb/tb_logic_result_checker.sv
// Directed, table-driven bench for logic_result_checker.
module tb_logic_result_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       smp_valid = 1'b0;
    logic [2:0] in_vec = '0;
    logic       out_1 = 1'b0;
    logic       out_2 = 1'b0;
    logic       busy, done, ovf, err_valid;
    logic       err_ready = 1'b0;
    logic [7:0] pass_cnt, fail_cnt;
    logic [4:0] err_data;

    int total = 0;
    int bad   = 0;

    logic_result_checker #(
        .NUM_VECTORS(8),
        .CNT_W      (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .smp_valid(smp_valid),
        .in_vec   (in_vec),
        .out_1    (out_1),
        .out_2    (out_2),
        .busy     (busy),
        .done     (done),
        .pass_cnt (pass_cnt),
        .fail_cnt (fail_cnt),
        .ovf      (ovf),
        .err_valid(err_valid),
        .err_ready(err_ready),
        .err_data (err_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] vec;
        logic       o1;
        logic       o2;
        int         pass;
        int         fail;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl[8];

    function automatic logic e1(input logic [2:0] v);
        return v[0] & v[1] & v[2];
    endfunction

    function automatic logic e2(input logic [2:0] v);
        return (v[0] & v[1]) | v[2];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic smp(input logic [2:0] v, input logic o1, input logic o2);
        smp_valid = 1'b1;
        in_vec    = v;
        out_1     = o1;
        out_2     = o2;
        cyc();
        smp_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        // Correct stage outputs for in_vec 0..7, hand-computed
        tbl[0] = '{3'd0, 1'b0, 1'b0, 1, 0, 1'b1, 1'b0};
        tbl[1] = '{3'd1, 1'b0, 1'b0, 2, 0, 1'b1, 1'b0};
        tbl[2] = '{3'd2, 1'b0, 1'b0, 3, 0, 1'b1, 1'b0};
        tbl[3] = '{3'd3, 1'b0, 1'b1, 4, 0, 1'b1, 1'b0};
        tbl[4] = '{3'd4, 1'b0, 1'b1, 5, 0, 1'b1, 1'b0};
        tbl[5] = '{3'd5, 1'b0, 1'b1, 6, 0, 1'b1, 1'b0};
        tbl[6] = '{3'd6, 1'b0, 1'b1, 7, 0, 1'b1, 1'b0};
        tbl[7] = '{3'd7, 1'b1, 1'b1, 8, 0, 1'b0, 1'b1};

        // Reset state
        cyc();
        cyc();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass_cnt, 0);
        chk("rst_fail", fail_cnt, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_errv", err_valid, 0);
        chk("rst_errd", err_data, 0);
        rst = 1'b0;
        cyc();

        // Run 1: all-correct vectors from the table
        pulse_start();
        chk("r1_busy", busy, 1);
        for (int i = 0; i < 8; i++) begin
            smp(tbl[i].vec, tbl[i].o1, tbl[i].o2);
            chk($sformatf("r1_pass%0d", i), pass_cnt, tbl[i].pass);
            chk($sformatf("r1_fail%0d", i), fail_cnt, tbl[i].fail);
            chk($sformatf("r1_busy%0d", i), busy, tbl[i].busy);
            chk($sformatf("r1_done%0d", i), done, tbl[i].done);
        end
        chk("r1_errv", err_valid, 0);
        // Samples in DONE are ignored
        smp(3'd7, 1'b0, 1'b0);
        chk("r1_done_ign_fail", fail_cnt, 0);
        chk("r1_done_ign_pass", pass_cnt, 8);
        chk("r1_done_ign_errv", err_valid, 0);

        // Run 2: out_1 forced low on in_vec=7
        pulse_start();
        chk("r2_clr_pass", pass_cnt, 0);
        chk("r2_clr_done", done, 0);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            smp(v, (i == 7) ? 1'b0 : e1(v), e2(v));
        end
        chk("r2_pass", pass_cnt, 7);
        chk("r2_fail", fail_cnt, 1);
        chk("r2_done", done, 1);
        chk("r2_errv", err_valid, 1);
        chk("r2_errd", err_data, 5'b111_0_1);
        err_ready = 1'b1;
        cyc();
        err_ready = 1'b0;
        chk("r2_errv_pop", err_valid, 0);

        // Run 3: out_2 inverted everywhere, no draining -> overflow
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            smp(v, e1(v), ~e2(v));
        end
        chk("r3_fail", fail_cnt, 8);
        chk("r3_pass", pass_cnt, 0);
        chk("r3_ovf", ovf, 1);
        for (int j = 0; j < 4; j++) begin
            logic [2:0] v;
            v = 3'(j);
            chk($sformatf("r3_errv%0d", j), err_valid, 1);
            chk($sformatf("r3_errd%0d", j), err_data, {v, e1(v), ~e2(v)});
            err_ready = 1'b1;
            cyc();
            err_ready = 1'b0;
        end
        chk("r3_empty", err_valid, 0);
        chk("r3_hold", err_data, {3'd3, 1'b0, 1'b0});

        // Run 4: full FIFO with simultaneous pop and push
        pulse_start();
        chk("r4_clr_ovf", ovf, 0);
        chk("r4_clr_fail", fail_cnt, 0);
        for (int i = 0; i < 4; i++) begin
            logic [2:0] v;
            v = 3'(i);
            smp(v, e1(v), ~e2(v));
        end
        chk("r4_full_ovf", ovf, 0);
        err_ready = 1'b1;
        smp(3'd4, 1'b0, 1'b0);
        err_ready = 1'b0;
        chk("r4_pp_ovf", ovf, 0);
        chk("r4_pp_fail", fail_cnt, 5);
        for (int j = 1; j < 5; j++) begin
            logic [2:0] v;
            v = 3'(j);
            chk($sformatf("r4_errv%0d", j), err_valid, 1);
            chk($sformatf("r4_errd%0d", j), err_data, {v, e1(v), ~e2(v)});
            err_ready = 1'b1;
            cyc();
            err_ready = 1'b0;
        end
        chk("r4_empty", err_valid, 0);
        for (int i = 5; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            smp(v, e1(v), e2(v));
        end
        chk("r4_done", done, 1);
        chk("r4_pass", pass_cnt, 3);
        chk("r4_fail", fail_cnt, 5);

        // Run 5: start ignored in RUN, then rst mid-run
        pulse_start();
        smp(3'd0, 1'b0, 1'b0);
        smp(3'd1, 1'b0, 1'b0);
        smp(3'd2, 1'b0, 1'b1);
        chk("r5_pass", pass_cnt, 2);
        chk("r5_fail", fail_cnt, 1);
        pulse_start();
        chk("r5_start_busy", busy, 1);
        chk("r5_start_pass", pass_cnt, 2);
        chk("r5_start_errv", err_valid, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("r5_rst_busy", busy, 0);
        chk("r5_rst_done", done, 0);
        chk("r5_rst_pass", pass_cnt, 0);
        chk("r5_rst_fail", fail_cnt, 0);
        chk("r5_rst_errv", err_valid, 0);

        // Run 6: IDLE samples ignored, then a fresh run counts only its own samples
        smp(3'd7, 1'b0, 1'b0);
        smp(3'd3, 1'b1, 1'b1);
        chk("r6_idle_pass", pass_cnt, 0);
        chk("r6_idle_fail", fail_cnt, 0);
        chk("r6_idle_busy", busy, 0);
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            smp(tbl[i].vec, tbl[i].o1, tbl[i].o2);
        end
        chk("r6_pass", pass_cnt, 8);
        chk("r6_fail", fail_cnt, 0);
        chk("r6_done", done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
